// File: rtl/amiga_serial_bridge.sv
// amiga_serial_bridge: host-side 8N1 serial bridge to Paula's rxd/txd pins.
// TX serialises host bytes onto o_ser_rxd; RX deserialises i_ser_txd into a buffer.
// Build option: define AMIGA_SERIAL_BRIDGE_RXFIFO_EN for a 2^RXFIFO_AW-entry RX FIFO,
// otherwise the RX buffer is a single holding register.
module amiga_serial_bridge #(
    parameter int unsigned DIV       = 62,
    parameter int unsigned RXFIFO_AW = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_clk7_en,
    input  logic [7:0] i_h_tx_data,
    input  logic       i_h_tx_valid,
    output logic       o_h_tx_ready,
    output logic [7:0] o_h_rx_data,
    output logic       o_h_rx_valid,
    input  logic       i_h_rx_ready,
    input  logic       i_clr_err,
    output logic       o_rx_ovf,
    output logic       o_rx_ferr,
    output logic       o_ser_rxd,
    input  logic       i_ser_txd
);

    localparam logic [15:0] DivM1  = 16'(DIV - 1);
    localparam logic [15:0] HalfM1 = 16'(DIV / 2 - 1);

    if (DIV < 4 || DIV > 65535 || RXFIFO_AW < 1 || RXFIFO_AW > 12) begin : g_param_check
        $error("amiga_serial_bridge: DIV or RXFIFO_AW out of range");
    end

    // ---------------------------------------------------------------- TX
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    tx_state_e   r_tx_state, w_tx_state;
    logic [15:0] r_tx_cnt, w_tx_cnt;
    logic [2:0]  r_tx_idx, w_tx_idx;
    logic [7:0]  r_tx_byte, w_tx_byte;
    logic        r_rxd, w_rxd;
    logic        w_tx_zero;

    assign w_tx_zero    = (r_tx_cnt == 16'd0);
    assign o_h_tx_ready = (r_tx_state == TxIdle);
    assign o_ser_rxd    = r_rxd;

    // TX next-state: each state lasts DIV ticks; the line level is registered with the state
    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_cnt   = r_tx_cnt;
        w_tx_idx   = r_tx_idx;
        w_tx_byte  = r_tx_byte;
        w_rxd      = r_rxd;
        if (i_clk7_en) begin
            unique case (r_tx_state)
                TxIdle: begin
                    if (i_h_tx_valid) begin
                        w_tx_byte  = i_h_tx_data;
                        w_rxd      = 1'b0;
                        w_tx_cnt   = DivM1;
                        w_tx_state = TxStart;
                    end
                end
                TxStart: begin
                    if (w_tx_zero) begin
                        w_rxd      = r_tx_byte[0];
                        w_tx_idx   = 3'd0;
                        w_tx_cnt   = DivM1;
                        w_tx_state = TxData;
                    end else begin
                        w_tx_cnt = r_tx_cnt - 16'd1;
                    end
                end
                TxData: begin
                    if (w_tx_zero) begin
                        w_tx_cnt = DivM1;
                        if (r_tx_idx == 3'd7) begin
                            w_rxd      = 1'b1;
                            w_tx_state = TxStop;
                        end else begin
                            w_tx_idx = r_tx_idx + 3'd1;
                            w_rxd    = r_tx_byte[r_tx_idx + 3'd1];
                        end
                    end else begin
                        w_tx_cnt = r_tx_cnt - 16'd1;
                    end
                end
                TxStop: begin
                    if (w_tx_zero) begin
                        w_tx_state = TxIdle;
                    end else begin
                        w_tx_cnt = r_tx_cnt - 16'd1;
                    end
                end
                default: w_tx_state = TxIdle;
            endcase
        end
    end

    // TX state register; reset forces the line idle-high on the same edge
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_tx_state <= TxIdle;
            r_tx_cnt   <= 16'd0;
            r_tx_idx   <= 3'd0;
            r_tx_byte  <= 8'h00;
            r_rxd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_idx   <= w_tx_idx;
            r_tx_byte  <= w_tx_byte;
            r_rxd      <= w_rxd;
        end
    end

    // ---------------------------------------------------------------- RX
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;

    rx_state_e   r_rx_state, w_rx_state;
    logic [15:0] r_rx_cnt, w_rx_cnt;
    logic [2:0]  r_rx_idx, w_rx_idx;
    logic [7:0]  r_rx_shift, w_rx_shift;
    logic        r_sync1, r_sync2, r_sync3;
    logic        w_rx_zero, w_push, w_ferr_set, w_ovf_set, w_pop, w_rx_valid;

    assign w_rx_zero = (r_rx_cnt == 16'd0);
    assign w_pop     = i_clk7_en & w_rx_valid & i_h_rx_ready;

    // Two-flop synchroniser plus one delay flop for falling-edge detection
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else if (i_clk7_en) begin
            r_sync1 <= i_ser_txd;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // RX next-state: mid-bit sampling; RxBreak waits for the line to recover after a bad stop
    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_cnt   = r_rx_cnt;
        w_rx_idx   = r_rx_idx;
        w_rx_shift = r_rx_shift;
        w_push     = 1'b0;
        w_ferr_set = 1'b0;
        if (i_clk7_en) begin
            unique case (r_rx_state)
                RxIdle: begin
                    if (r_sync3 && !r_sync2) begin
                        w_rx_cnt   = HalfM1;
                        w_rx_state = RxStart;
                    end
                end
                RxStart: begin
                    if (w_rx_zero) begin
                        if (!r_sync2) begin
                            w_rx_cnt   = DivM1;
                            w_rx_idx   = 3'd0;
                            w_rx_state = RxData;
                        end else begin
                            w_rx_state = RxIdle;
                        end
                    end else begin
                        w_rx_cnt = r_rx_cnt - 16'd1;
                    end
                end
                RxData: begin
                    if (w_rx_zero) begin
                        w_rx_shift = {r_sync2, r_rx_shift[7:1]};
                        w_rx_cnt   = DivM1;
                        if (r_rx_idx == 3'd7) begin
                            w_rx_state = RxStop;
                        end else begin
                            w_rx_idx = r_rx_idx + 3'd1;
                        end
                    end else begin
                        w_rx_cnt = r_rx_cnt - 16'd1;
                    end
                end
                RxStop: begin
                    if (w_rx_zero) begin
                        if (r_sync2) begin
                            w_push     = 1'b1;
                            w_rx_state = RxIdle;
                        end else begin
                            w_ferr_set = 1'b1;
                            w_rx_state = RxBreak;
                        end
                    end else begin
                        w_rx_cnt = r_rx_cnt - 16'd1;
                    end
                end
                RxBreak: begin
                    if (r_sync2) begin
                        w_rx_state = RxIdle;
                    end
                end
                default: w_rx_state = RxIdle;
            endcase
        end
    end

    // RX state register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rx_state <= RxIdle;
            r_rx_cnt   <= 16'd0;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_state <= w_rx_state;
            r_rx_cnt   <= w_rx_cnt;
            r_rx_idx   <= w_rx_idx;
            r_rx_shift <= w_rx_shift;
        end
    end

    // ---------------------------------------------------------------- RX buffer
`ifdef AMIGA_SERIAL_BRIDGE_RXFIFO_EN
    logic [7:0]           r_mem [1 << RXFIFO_AW];
    logic [RXFIFO_AW-1:0] r_wr, r_rd;
    logic [RXFIFO_AW:0]   r_cnt;
    logic                 w_full, w_wr;

    // Count MSB alone marks full because the count never exceeds the depth
    assign w_full      = r_cnt[RXFIFO_AW];
    assign w_wr        = w_push & (~w_full | w_pop);
    assign w_ovf_set   = w_push & w_full & ~w_pop;
    assign w_rx_valid  = (r_cnt != '0);
    assign o_h_rx_data = r_mem[r_rd];

    // FIFO storage and pointers; a write at full only happens alongside a pop
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < (1 << RXFIFO_AW); i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= r_rx_shift;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_hold_v;

    assign w_ovf_set   = w_push & r_hold_v & ~w_pop;
    assign w_rx_valid  = r_hold_v;
    assign o_h_rx_data = r_hold;

    // Single holding register; a completing byte replaces it only if empty or being popped
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_hold   <= 8'h00;
            r_hold_v <= 1'b0;
        end else if (w_push && (!r_hold_v || w_pop)) begin
            r_hold   <= r_rx_shift;
            r_hold_v <= 1'b1;
        end else if (w_pop) begin
            r_hold_v <= 1'b0;
        end
    end
`endif

    assign o_h_rx_valid = w_rx_valid;

    // Sticky error flags; a new error on the clearing tick wins
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_rx_ovf  <= 1'b0;
            o_rx_ferr <= 1'b0;
        end else if (i_clk7_en) begin
            if (w_ovf_set) begin
                o_rx_ovf <= 1'b1;
            end else if (i_clr_err) begin
                o_rx_ovf <= 1'b0;
            end
            if (w_ferr_set) begin
                o_rx_ferr <= 1'b1;
            end else if (i_clr_err) begin
                o_rx_ferr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_amiga_serial_bridge.sv
// Scoreboard bench for amiga_serial_bridge (DIV=4). Received bytes are checked by a
// monitor against a queue of expected bytes; line-level and flag checks are inline.
module tb_amiga_serial_bridge;

    localparam int unsigned DIV = 4;
`ifdef AMIGA_SERIAL_BRIDGE_RXFIFO_EN
    localparam int KEEP = 16;
`else
    localparam int KEEP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic       drv_txd = 1'b1;
    logic       loop = 1'b0;
    logic       tx_ready, rx_valid, rx_ovf, rx_ferr, ser_rxd, ser_txd;
    logic [7:0] rx_data;
    logic [7:0] mon_exp;

    int         n_pass = 0;
    int         n_total = 0;
    int         en_phase = 0;
    logic [7:0] exp_q[$];

    assign ser_txd = loop ? ser_rxd : drv_txd;

    amiga_serial_bridge #(.DIV(DIV), .RXFIFO_AW(4)) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_clk7_en    (en),
        .i_h_tx_data  (tx_data),
        .i_h_tx_valid (tx_valid),
        .o_h_tx_ready (tx_ready),
        .o_h_rx_data  (rx_data),
        .o_h_rx_valid (rx_valid),
        .i_h_rx_ready (rx_ready),
        .i_clr_err    (clr_err),
        .o_rx_ovf     (rx_ovf),
        .o_rx_ferr    (rx_ferr),
        .o_ser_rxd    (ser_rxd),
        .i_ser_txd    (ser_txd)
    );

    always #5 clk = ~clk;

    // Clock enable pattern 1,1,0 changes just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            en_phase = (en_phase + 1) % 3;
            en = (en_phase != 2);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: values seen at the falling edge are those the next rising edge uses
    always @(negedge clk) begin
        if (en && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check("rx_unexpected_byte", int'(rx_data), -1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_byte", int'(rx_data), int'(mon_exp));
            end
        end
    end

    // Advance to just after the next enabled rising edge
    task automatic tick();
        do @(posedge clk); while (!en);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        int guard = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) check("tx_ready_timeout", 0, 1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        check("rx_drain_remaining", exp_q.size(), 0);
    endtask

    task automatic tx_frame_check(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        send(b);
        for (int j = 0; j < 10 * int'(DIV); j++) begin
            check("tx_line", int'(ser_rxd), int'(fr[j / int'(DIV)]));
            check("tx_ready_busy", int'(tx_ready), 0);
            tick();
        end
        check("tx_ready_after_frame", int'(tx_ready), 1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        drv_txd = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 8; i++) begin
            drv_txd = b[i];
            repeat (DIV) tick();
        end
        drv_txd = stop;
        repeat (DIV) tick();
        drv_txd = 1'b1;
    endtask

    initial begin
        logic [7:0] lb [3];
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h3C;

        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b1;
        check("reset_ser_rxd", int'(ser_rxd), 1);
        check("reset_tx_ready", int'(tx_ready), 1);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_ovf", int'(rx_ovf), 0);
        check("reset_rx_ferr", int'(rx_ferr), 0);

        // TX frame shape for 0xA5
        tick();
        tx_frame_check(8'hA5);

        // Loopback, back-to-back bytes
        loop = 1'b1;
        rx_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(lb[i]);
            send(lb[i]);
        end
        wait_drain(50 * DIV);
        check("loop_ferr", int'(rx_ferr), 0);
        check("loop_ovf", int'(rx_ovf), 0);
        repeat (2 * DIV) tick();
        loop = 1'b0;

        // One-tick glitch is rejected
        repeat (5) tick();
        drv_txd = 1'b0;
        tick();
        drv_txd = 1'b1;
        repeat (10 * DIV) tick();
        check("glitch_ferr", int'(rx_ferr), 0);
        check("glitch_ovf", int'(rx_ovf), 0);
        check("glitch_rx_valid", int'(rx_valid), 0);

        // Externally driven good frame
        exp_q.push_back(8'h96);
        drive_frame(8'h96, 1'b1);
        wait_drain(6 * DIV);

        // Framing error, then clear
        drive_frame(8'h55, 1'b0);
        repeat (3 * DIV) tick();
        check("ferr_set", int'(rx_ferr), 1);
        check("ferr_no_byte", int'(rx_valid), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ferr_cleared", int'(rx_ferr), 0);

        // Overflow with host stalled
        rx_ready = 1'b0;
        loop = 1'b1;
        for (int i = 0; i <= KEEP; i++) send(8'(i * 37 + 5));
        repeat (12 * DIV) tick();
        check("ovf_set", int'(rx_ovf), 1);
        check("ovf_rx_valid", int'(rx_valid), 1);
        check("ovf_head_byte", int'(rx_data), 5);
        loop = 1'b0;
        for (int i = 0; i < KEEP; i++) exp_q.push_back(8'(i * 37 + 5));
        rx_ready = 1'b1;
        wait_drain(4 * KEEP + 20);
        tick();
        check("ovf_drained_valid", int'(rx_valid), 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_cleared", int'(rx_ovf), 0);

        // Reset in the middle of a TX data bit
        send(8'h5A);
        repeat (2 * DIV + 1) tick();
        check("midframe_busy", int'(tx_ready), 0);
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        check("midreset_ser_rxd", int'(ser_rxd), 1);
        check("midreset_tx_ready", int'(tx_ready), 1);
        reset_n = 1'b1;
        tick();
        tx_frame_check(8'hC3);

        repeat (20) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
